// File: rtl/demux_1x64b_to_8x64b_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_1x64b_to_8x64b_buf_pkg
// Brief    : Shared wavepool definitions for the 8x64b slot-line scatter
//            buffer: geometry constants, buffer state encoding, helpers.
// Revision : 1.0 - initial release
// ============================================================================
package demux_1x64b_to_8x64b_buf_pkg;

  localparam int NUM_SLOTS  = 8;
  localparam int SLOT_WIDTH = 64;
  localparam int SLOT_SEL_W = 3;
  localparam int LINE_WIDTH = NUM_SLOTS * SLOT_WIDTH;

  // Per-buffer line state
  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'b00,
    BUF_FILLING = 2'b01,
    BUF_FULL    = 2'b10
  } buf_state_t;

  // One-hot mask bit for a slot index
  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_SEL_W-1:0] slot);
    return NUM_SLOTS'(1) << slot;
  endfunction

endpackage : demux_1x64b_to_8x64b_buf_pkg
`default_nettype wire

// File: rtl/demux_1x64b_to_8x64b_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_1x64b_to_8x64b_buf_if
// Brief    : Beat-in / line-out bus of the slot-line scatter buffer.
//            master = beat source and line consumer, slave = buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface demux_1x64b_to_8x64b_buf_if;
  import demux_1x64b_to_8x64b_buf_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [SLOT_SEL_W-1:0] in_slot;
  logic [SLOT_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [LINE_WIDTH-1:0] out_data;
  logic [NUM_SLOTS-1:0]  out_mask;
  logic                  err_dup;

  modport master (
    output in_valid, in_slot, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_mask, err_dup
  );

  modport slave (
    input  in_valid, in_slot, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_mask, err_dup
  );

endinterface : demux_1x64b_to_8x64b_buf_if
`default_nettype wire

// File: rtl/demux_1x64b_to_8x64b_buf_line_slot_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_slot_buffer
// Brief    : One 8x64b line with slot-written mask and EMPTY/FILLING/FULL
//            state. Slot write port plus a clear used when the line drains.
//            Output data is masked so unwritten slots read as zero.
// Revision : 1.0 - initial release
// ============================================================================
module line_slot_buffer
  import demux_1x64b_to_8x64b_buf_pkg::*;
(
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_wr_en,
  input  wire logic [SLOT_SEL_W-1:0] i_wr_slot,
  input  wire logic [SLOT_WIDTH-1:0] i_wr_data,
  input  wire logic                  i_wr_last,
  input  wire logic                  i_clr,
  output buf_state_t                 o_state,
  output buf_state_t                 o_state_nxt,
  output logic [NUM_SLOTS-1:0]       o_mask,
  output logic [LINE_WIDTH-1:0]      o_data
);

  buf_state_t            r_state;
  buf_state_t            w_state_nxt;
  logic [NUM_SLOTS-1:0]  r_mask;
  logic [NUM_SLOTS-1:0]  w_mask_nxt;
  logic [SLOT_WIDTH-1:0] r_data [NUM_SLOTS];

  // State and mask registers; cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BUF_EMPTY;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  // Next state: a drain empties the line, a write fills it and in_last closes it
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    if (i_clr) begin
      w_state_nxt = BUF_EMPTY;
      w_mask_nxt  = '0;
    end else if (i_wr_en) begin
      w_mask_nxt  = r_mask | slot_onehot(i_wr_slot);
      w_state_nxt = i_wr_last ? BUF_FULL : BUF_FILLING;
    end
  end

  // Slot storage is never reset; stale contents are hidden by the mask
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_wr_slot] <= i_wr_data;
    end
  end

  // Present the line with unwritten slots forced to zero
  always_comb begin
    o_data = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (r_mask[i]) begin
        o_data[i*SLOT_WIDTH +: SLOT_WIDTH] = r_data[i];
      end
    end
  end

  assign o_state     = r_state;
  assign o_state_nxt = w_state_nxt;
  assign o_mask      = r_mask;

endmodule : line_slot_buffer
`default_nettype wire

// File: rtl/demux_1x64b_to_8x64b_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux_1x64b_to_8x64b_buf
// Brief    : Scatter side of the wavepool 8x64b slot lines. Slot-tagged 64b
//            beats fill a 512b line in a ping-pong pair of line buffers;
//            completed lines are presented with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1x64b_to_8x64b_buf
  import demux_1x64b_to_8x64b_buf_pkg::*;
(
  input  wire logic                  clk,
  input  wire logic                  rst,
  demux_1x64b_to_8x64b_buf_if.slave  bus
);

  localparam int C_NUM_BUFS = 2;

  logic                  r_wr_buf;
  logic                  r_rd_buf;
  logic                  r_in_ready;
  logic                  r_err_dup;

  logic                  w_accept;
  logic                  w_drain;
  logic                  w_wr_buf_nxt;
  logic                  w_rd_buf_nxt;
  logic                  w_in_ready_nxt;
  logic                  w_dup;

  buf_state_t            w_state     [C_NUM_BUFS];
  buf_state_t            w_state_nxt [C_NUM_BUFS];
  logic [NUM_SLOTS-1:0]  w_mask      [C_NUM_BUFS];
  logic [LINE_WIDTH-1:0] w_data      [C_NUM_BUFS];

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_drain  = bus.out_valid && bus.out_ready;

  // Two line buffers: the write pointer selects the filling one, the read
  // pointer the one being drained; they never coincide on a drain+write.
  for (genvar b = 0; b < C_NUM_BUFS; b++) begin : g_buf
    line_slot_buffer u_line (
      .clk         (clk),
      .rst         (rst),
      .i_wr_en     (w_accept && (r_wr_buf == 1'(b))),
      .i_wr_slot   (bus.in_slot),
      .i_wr_data   (bus.in_data),
      .i_wr_last   (bus.in_last),
      .i_clr       (w_drain && (r_rd_buf == 1'(b))),
      .o_state     (w_state[b]),
      .o_state_nxt (w_state_nxt[b]),
      .o_mask      (w_mask[b]),
      .o_data      (w_data[b])
    );
  end

  // Pointer advance, registered ready and duplicate-write detection
  always_comb begin
    w_wr_buf_nxt   = r_wr_buf;
    w_rd_buf_nxt   = r_rd_buf;
    if (w_accept && bus.in_last) begin
      w_wr_buf_nxt = ~r_wr_buf;
    end
    if (w_drain) begin
      w_rd_buf_nxt = ~r_rd_buf;
    end
    w_in_ready_nxt = (w_state_nxt[w_wr_buf_nxt] != BUF_FULL);
    w_dup          = w_accept && w_mask[r_wr_buf][bus.in_slot];
  end

  // Pointer and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_buf   <= 1'b0;
      r_rd_buf   <= 1'b0;
      r_in_ready <= 1'b1;
      r_err_dup  <= 1'b0;
    end else begin
      r_wr_buf   <= w_wr_buf_nxt;
      r_rd_buf   <= w_rd_buf_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_err_dup  <= w_dup;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.err_dup   = r_err_dup;
  assign bus.out_valid = (w_state[r_rd_buf] == BUF_FULL);
  assign bus.out_mask  = w_mask[r_rd_buf];
  assign bus.out_data  = w_data[r_rd_buf];

endmodule : demux_1x64b_to_8x64b_buf
`default_nettype wire

// File: tb/tb_demux_1x64b_to_8x64b_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1x64b_to_8x64b_buf
// Brief    : Self-checking bench for the slot-line scatter buffer. A queue of
//            completed lines plus one partial line stands in for the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1x64b_to_8x64b_buf;
  import demux_1x64b_to_8x64b_buf_pkg::*;

  typedef struct packed {
    logic [LINE_WIDTH-1:0] d;
    logic [NUM_SLOTS-1:0]  m;
  } line_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model: finished lines awaiting the consumer, plus the line being filled
  line_t                 m_fq [$];
  logic [SLOT_WIDTH-1:0] m_part [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  m_pmask = '0;
  logic                  m_dup   = 1'b0;
  logic                  acc;

  always #5 clk = ~clk;

  demux_1x64b_to_8x64b_buf_if bus ();

  demux_1x64b_to_8x64b_buf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [LINE_WIDTH-1:0] obs, input logic [LINE_WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_WIDTH-1:0] build(input logic [NUM_SLOTS-1:0] m);
    logic [LINE_WIDTH-1:0] d = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (m[i]) d[i*SLOT_WIDTH +: SLOT_WIDTH] = m_part[i];
    return d;
  endfunction

  task automatic model_reset();
    m_fq.delete();
    m_pmask = '0;
    m_dup   = 1'b0;
  endtask

  // Compare every output against the model; with no finished line the
  // presented buffer is the one being filled.
  task automatic check_outputs(input string tag);
    chk({tag, ":in_ready"},  LINE_WIDTH'(bus.in_ready),  LINE_WIDTH'(m_fq.size() < 2));
    chk({tag, ":out_valid"}, LINE_WIDTH'(bus.out_valid), LINE_WIDTH'(m_fq.size() > 0));
    chk({tag, ":err_dup"},   LINE_WIDTH'(bus.err_dup),   LINE_WIDTH'(m_dup));
    if (m_fq.size() > 0) begin
      chk({tag, ":out_mask"}, LINE_WIDTH'(bus.out_mask), LINE_WIDTH'(m_fq[0].m));
      chk({tag, ":out_data"}, bus.out_data, m_fq[0].d);
    end else begin
      chk({tag, ":out_mask"}, LINE_WIDTH'(bus.out_mask), LINE_WIDTH'(m_pmask));
      chk({tag, ":out_data"}, bus.out_data, build(m_pmask));
    end
  endtask

  // One clock cycle: drive, advance model across the edge, then compare
  task automatic cyc(input logic v, input logic [SLOT_SEL_W-1:0] s, input logic [SLOT_WIDTH-1:0] d,
                     input logic l, input logic ordy, input string tag, output logic accepted);
    logic  drn;
    line_t ln;
    bus.in_valid  = v;
    bus.in_slot   = s;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    accepted = v && (m_fq.size() < 2);
    drn      = (m_fq.size() > 0) && ordy;
    @(posedge clk);
    #1;
    m_dup = accepted && m_pmask[s];
    if (drn) void'(m_fq.pop_front());
    if (accepted) begin
      m_part[s]  = d;
      m_pmask[s] = 1'b1;
      if (l) begin
        ln.m = m_pmask;
        ln.d = build(m_pmask);
        m_fq.push_back(ln);
        m_pmask = '0;
      end
    end
    check_outputs(tag);
  endtask

  initial begin
    logic [SLOT_SEL_W-1:0] r_s;
    logic [SLOT_WIDTH-1:0] r_d;
    logic                  r_l;
    logic                  r_v;

    bus.in_valid  = 1'b0;
    bus.in_slot   = '0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();

    // 1. reset held three cycles
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset:out_data_zero", bus.out_data, '0);
    rst = 1'b0;

    // 2. full line, slots 0..7, closed by slot 7
    for (int i = 0; i < NUM_SLOTS; i++)
      cyc(1'b1, SLOT_SEL_W'(i), 64'h1111_0000_0000_0000 | 64'(i), (i == NUM_SLOTS - 1), 1'b0, "full", acc);
    chk("full:mask_ff", LINE_WIDTH'(bus.out_mask), LINE_WIDTH'(8'hFF));
    chk("full:slot7", LINE_WIDTH'(bus.out_data[511:448]), LINE_WIDTH'(64'h1111_0000_0000_0007));

    // 3. back-pressure: second line closes, third line's beat stalls
    cyc(1'b1, 3'd0, 64'h2222_0000, 1'b0, 1'b0, "bp_l2a", acc);
    cyc(1'b1, 3'd1, 64'h2222_0001, 1'b1, 1'b0, "bp_l2b", acc);
    chk("bp:ready_low", LINE_WIDTH'(bus.in_ready), '0);
    cyc(1'b1, 3'd4, 64'h3333_0004, 1'b1, 1'b0, "bp_stall", acc);
    chk("bp:stall_not_taken", LINE_WIDTH'(acc), '0);
    cyc(1'b1, 3'd4, 64'h3333_0004, 1'b1, 1'b1, "bp_drain", acc);
    chk("bp:line2_mask", LINE_WIDTH'(bus.out_mask), LINE_WIDTH'(8'h03));
    chk("bp:ready_back", LINE_WIDTH'(bus.in_ready), LINE_WIDTH'(1'b1));
    cyc(1'b1, 3'd4, 64'h3333_0004, 1'b1, 1'b0, "bp_l3", acc);
    cyc(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, "bp_d2", acc);
    cyc(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, "bp_d3", acc);

    // 4. partial line: slots 2 and 5
    cyc(1'b1, 3'd2, 64'hA, 1'b0, 1'b0, "part_a", acc);
    cyc(1'b1, 3'd5, 64'hB, 1'b1, 1'b0, "part_b", acc);
    chk("part:mask_24", LINE_WIDTH'(bus.out_mask), LINE_WIDTH'(8'h24));
    chk("part:data", bus.out_data, (LINE_WIDTH'(64'hB) << 320) | (LINE_WIDTH'(64'hA) << 128));
    cyc(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, "part_drain", acc);

    // 5. duplicate slot write
    cyc(1'b1, 3'd3, 64'hC, 1'b0, 1'b0, "dup_c", acc);
    chk("dup:no_pulse_first", LINE_WIDTH'(bus.err_dup), '0);
    cyc(1'b1, 3'd3, 64'hD, 1'b0, 1'b0, "dup_d", acc);
    chk("dup:pulse", LINE_WIDTH'(bus.err_dup), LINE_WIDTH'(1'b1));
    cyc(1'b1, 3'd0, 64'hE, 1'b1, 1'b0, "dup_last", acc);
    chk("dup:pulse_ends", LINE_WIDTH'(bus.err_dup), '0);
    chk("dup:mask_09", LINE_WIDTH'(bus.out_mask), LINE_WIDTH'(8'h09));
    chk("dup:slot3", LINE_WIDTH'(bus.out_data[255:192]), LINE_WIDTH'(64'hD));
    cyc(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, "dup_drain", acc);

    // 6. reset in the middle of a line, asserted between clock edges
    cyc(1'b1, 3'd0, 64'h50, 1'b0, 1'b0, "rmid_0", acc);
    cyc(1'b1, 3'd6, 64'h56, 1'b0, 1'b0, "rmid_6", acc);
    cyc(1'b1, 3'd7, 64'h57, 1'b0, 1'b0, "rmid_7", acc);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rmid_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 3'd1, 64'h61, 1'b1, 1'b0, "rmid_new", acc);
    chk("rmid:mask_02", LINE_WIDTH'(bus.out_mask), LINE_WIDTH'(8'h02));
    cyc(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, "rmid_drain", acc);

    // Randomised traffic; a refused beat is held until it is taken
    r_v = 1'b0;
    r_s = '0;
    r_d = '0;
    r_l = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!r_v || acc) begin
        r_v = ($urandom_range(0, 9) < 7);
        r_s = SLOT_SEL_W'($urandom_range(0, NUM_SLOTS - 1));
        r_d = {$urandom, $urandom};
        r_l = ($urandom_range(0, 4) == 0);
      end
      cyc(r_v, r_s, r_d, r_l, 1'($urandom_range(0, 1)), "rand", acc);
    end
    bus.in_valid = 1'b0;
    repeat (3) cyc(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, "flush", acc);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_demux_1x64b_to_8x64b_buf
`default_nettype wire
